// File: rtl/jtag_shift_master.sv
// Command-driven JTAG host: walks the TAP through reset, IR/DR scans and idle clocks, returns TDO bits.
// Optional expect/mask compare of the captured bits is enabled with JTAG_SHIFT_MASTER_CHECK_EN.
module jtag_shift_master #(
    parameter int MAX_LEN = 32,
    parameter int TCK_DIV = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
    input  logic [MAX_LEN-1:0] cmd_expect,
    input  logic [MAX_LEN-1:0] cmd_mask,
    output logic               rsp_mismatch,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] RST_LAST = BIT_W'(5);

    typedef enum logic [2:0] {IDLE, PRE_RST, NAV, SHIFT, EXIT, RTI, WAIT_CLK, RESP} state_t;

    state_t             r_state, w_state_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [DIV_W-1:0]   r_div;
    logic               r_tck, r_tms, r_tdi, r_tap_known;
    logic [1:0]         r_type;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data, r_cap, r_rsp_data;

    logic               w_accept, w_active, w_fall, w_rise, w_step, w_from_idle;
    logic               w_tms_nxt, w_tdi_nxt;
    logic [1:0]         w_type;
    logic [LEN_W-1:0]   w_len_in;
    logic [BIT_W-1:0]   w_len_b, w_nav_last;
    logic [MAX_LEN-1:0] w_data;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_active    = (r_state != IDLE) && (r_state != RESP);
    assign w_fall      = r_tck && (r_div == DIV_LAST);
    assign w_rise      = !r_tck && (r_div == DIV_LAST) && w_active;
    assign w_step      = w_accept || w_fall;
    assign w_from_idle = (r_state == IDLE);
    assign w_len_in    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    // On the accept edge the command is not latched yet, so look at the inputs directly
    assign w_type      = w_from_idle ? cmd_type : r_type;
    assign w_len_b     = w_from_idle ? BIT_W'(w_len_in) : BIT_W'(r_len);
    assign w_data      = w_from_idle ? cmd_data : r_data;
    assign w_nav_last  = (w_type == 2'd1) ? BIT_W'(3) : BIT_W'(2);

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);
    assign busy      = w_active;
    assign rsp_data  = r_rsp_data;
    assign TCK       = r_tck;
    assign TMS       = r_tms;
    assign TDI       = r_tdi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next TCK-cycle position, plus the TMS/TDI that go with it
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_tms_nxt   = 1'b0;
        w_tdi_nxt   = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_bit_nxt = '0;
                if (cmd_type == 2'd0 || (w_len_in != '0 && !r_tap_known)) w_state_nxt = PRE_RST;
                else if (w_len_in == '0)                                   w_state_nxt = RESP;
                else if (cmd_type == 2'd3)                                 w_state_nxt = WAIT_CLK;
                else                                                       w_state_nxt = NAV;
            end
            PRE_RST: if (w_fall) begin
                if (r_bit != RST_LAST) w_bit_nxt = r_bit + BIT_W'(1);
                else begin
                    w_bit_nxt = '0;
                    if (r_type == 2'd0)      w_state_nxt = RESP;
                    else if (r_type == 2'd3) w_state_nxt = WAIT_CLK;
                    else                     w_state_nxt = NAV;
                end
            end
            NAV: if (w_fall) begin
                if (r_bit != w_nav_last) w_bit_nxt = r_bit + BIT_W'(1);
                else begin
                    w_bit_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: if (w_fall) begin
                if (r_bit != w_len_b - BIT_W'(1)) w_bit_nxt = r_bit + BIT_W'(1);
                else                              w_state_nxt = EXIT;
            end
            EXIT:     if (w_fall) w_state_nxt = RTI;
            RTI:      if (w_fall) w_state_nxt = RESP;
            WAIT_CLK: if (w_fall) begin
                if (r_bit != w_len_b - BIT_W'(1)) w_bit_nxt = r_bit + BIT_W'(1);
                else                              w_state_nxt = RESP;
            end
            RESP:     if (rsp_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        case (w_state_nxt)
            PRE_RST: w_tms_nxt = (w_bit_nxt != RST_LAST);
            NAV:     w_tms_nxt = (w_type == 2'd1) ? (w_bit_nxt < BIT_W'(2)) : (w_bit_nxt == '0);
            SHIFT: begin
                w_tms_nxt = (w_bit_nxt == w_len_b - BIT_W'(1));
                w_tdi_nxt = |(w_data & (MAX_LEN'(1) << w_bit_nxt));
            end
            EXIT:    w_tms_nxt = 1'b1;
            default: w_tms_nxt = 1'b0;
        endcase
    end

`ifdef JTAG_SHIFT_MASTER_CHECK_EN
    logic [MAX_LEN-1:0] r_expect, r_mask, w_lenmask;
    logic               r_mismatch;
    assign w_lenmask    = (r_len >= LEN_W'(MAX_LEN)) ? '1 : ((MAX_LEN'(1) << r_len) - MAX_LEN'(1));
    assign rsp_mismatch = r_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expect   <= '0;
            r_mask     <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_accept) begin
                r_expect <= cmd_expect;
                r_mask   <= cmd_mask;
            end
            if (w_state_nxt == RESP && r_state != RESP)
                r_mismatch <= w_from_idle ? 1'b0 : |((r_cap ^ r_expect) & r_mask & w_lenmask);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_div       <= '0;
            r_tap_known <= 1'b0;
            r_type      <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_type <= cmd_type;
                r_len  <= w_len_in;
                r_data <= cmd_data;
                r_cap  <= '0;
            end
            if (w_step) begin
                r_tck <= 1'b0;
                r_div <= '0;
                r_tms <= w_tms_nxt;
                r_tdi <= w_tdi_nxt;
            end else if (w_rise) begin
                r_tck <= 1'b1;
                r_div <= '0;
                if (r_state == SHIFT) r_cap <= r_cap | (MAX_LEN'(TDO) << r_bit);
            end else if (w_active) begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_fall && r_state == PRE_RST && r_bit == RST_LAST) r_tap_known <= 1'b1;
            if (w_state_nxt == RESP && r_state != RESP) r_rsp_data <= w_from_idle ? '0 : r_cap;
        end
    end
endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: behavioural TAP on the JTAG pins plus arithmetic reference for scans.
module tb_jtag_shift_master;
    localparam int MAX_LEN = 32;
    localparam int TCK_DIV = 2;
    localparam int LEN_W   = 6;
    localparam logic [31:0] IDCODE = 32'h1BA0_0477;

    logic               clk = 1'b0;
    logic               rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]         cmd_type;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data, rsp_data;
    logic               TCK, TMS, TDI, TDO;
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
    logic [MAX_LEN-1:0] cmd_expect, cmd_mask;
    logic               rsp_mismatch;
`endif

    always #5 clk = ~clk;

    jtag_shift_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
        .cmd_expect(cmd_expect), .cmd_mask(cmd_mask), .rsp_mismatch(rsp_mismatch),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    // IEEE 1149.1 TAP controller with a 4-bit IR, IDCODE (IR=1) and a 32-bit user DR (IR=2)
    typedef enum int {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                      SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDS  : RTI;
            SDS:  return m ? SIS  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDS  : RTI;
            SIS:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    tap_t        tap_st = PDR;
    logic [3:0]  tap_ir = 4'h1, ir_sr = 4'h0;
    logic [31:0] dr_sr = '0, tap_udr = '0;
    logic [63:0] mon_tms, mon_tdi;
    int          mon_n;

    assign TDO = (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

    always @(posedge TCK) begin
        if (mon_n < 64) begin
            mon_tms[mon_n] = TMS;
            mon_tdi[mon_n] = TDI;
        end
        mon_n++;
        case (tap_st)
            TLR:  tap_ir = 4'h1;
            CIR:  ir_sr = 4'b0001;
            SHIR: ir_sr = {TDI, ir_sr[3:1]};
            UIR:  tap_ir = ir_sr;
            CDR:  dr_sr = (tap_ir == 4'h1) ? IDCODE : (tap_ir == 4'h2) ? tap_udr : 32'h0;
            SHDR: dr_sr = {TDI, dr_sr[31:1]};
            UDR:  if (tap_ir == 4'h2) tap_udr = dr_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, TMS);
    end

    int          n_vec = 0, n_err = 0;
    logic        known = 1'b0;
    logic [3:0]  exp_ir = 4'h1;
    logic [31:0] exp_udr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_lines", {TCK, TMS, TDI, busy, rsp_valid}, 5'b01000);
        check("rst_data", rsp_data, 0);
        rst = 1'b0;
        known = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
    endtask

    // Issue one command, predict its pin sequence and response, check everything on completion
    task automatic run_cmd(input logic [1:0] t, input int len, input logic [31:0] d,
                           input logic [31:0] ex, input logic [31:0] mk, input int hold);
        int          le, n, cnt;
        logic [63:0] et, ed;
        logic [31:0] lm, er, cap;
        logic        em;
        le = (len > 32) ? 32 : len;
        lm = (le >= 32) ? 32'hFFFF_FFFF : ((32'd1 << le) - 32'd1);
        n = 0; et = '0; ed = '0; er = '0;
        if (t == 2'd0 || (le != 0 && !known)) begin
            for (int i = 0; i < 5; i++) begin et[n] = 1'b1; n++; end
            n++;
            known  = 1'b1;
            exp_ir = 4'h1;
        end
        if (le != 0 && (t == 2'd1 || t == 2'd2)) begin
            et[n] = 1'b1;
            if (t == 2'd1) begin et[n+1] = 1'b1; n += 4; end
            else n += 3;
            for (int i = 0; i < le; i++) begin
                ed[n+i] = d[i];
                et[n+i] = (i == le - 1);
            end
            n += le;
            et[n] = 1'b1;
            n += 2;
            if (t == 2'd1) begin
                er = 32'h1 & lm;
                if (le == 4) exp_ir = d[3:0];
            end else begin
                cap = (exp_ir == 4'h1) ? IDCODE : (exp_ir == 4'h2) ? exp_udr : 32'h0;
                er  = cap & lm;
                if (exp_ir == 4'h2) exp_udr = (le == 32) ? d : ((exp_udr >> le) | (d << (32 - le)));
            end
        end else if (t == 2'd3) begin
            n += le;
        end
        em = |((er ^ ex) & mk & lm);

        mon_n = 0; mon_tms = '0; mon_tdi = '0;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_type = t; cmd_len = LEN_W'(len); cmd_data = d; cmd_valid = 1'b1;
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
        cmd_expect = ex; cmd_mask = mk;
`endif
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 1;
        check("busy_after_accept", busy, (n > 0));
        while (!rsp_valid && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, 1 + 2 * TCK_DIV * n);
        check("rsp_data", rsp_data, er);
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
        check("rsp_mismatch", rsp_mismatch, em);
`endif
        check("tck_count", mon_n, n);
        check("tms_seq", mon_tms, et);
        check("tdi_seq", mon_tdi, ed);
        check("idle_lines", {TCK, TMS, TDI, busy}, 4'b0000);
        if (known) check("tap_in_rti", tap_st, RTI);
        if (hold > 0) begin
            cmd_type = 2'd3; cmd_len = 6'd4; cmd_valid = 1'b1;
            repeat (hold) @(negedge clk);
            check("hold_ready", cmd_ready, 0);
            check("hold_valid_data", {rsp_valid, rsp_data}, {1'b1, er});
            check("hold_no_tck", mon_n, n);
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_taken", {rsp_valid, cmd_ready}, 2'b01);
        if (hold > 0) check("stray_not_accepted", busy, 0);
    endtask

    initial begin
        logic [31:0] rd;
        int          m;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_type = '0; cmd_len = '0; cmd_data = '0;
`ifdef JTAG_SHIFT_MASTER_CHECK_EN
        cmd_expect = '0; cmd_mask = '0;
`endif
        mon_n = 0; mon_tms = '0; mon_tdi = '0;
        repeat (2) @(negedge clk);
        do_reset();

        run_cmd(2'd0, 0, 32'h0, 32'h0, 32'h0, 0);             // TAP reset, 25 clk
        do_reset();
        run_cmd(2'd1, 4, 32'h7, 32'h0, 32'h0, 0);             // IR scan with implied PRE_RST
        check("tap_ir_7", tap_ir, 4'h7);
        run_cmd(2'd1, 4, 32'h1, 32'h0, 32'h0, 0);
        run_cmd(2'd2, 32, 32'h0, 32'h0, 32'h0, 0);            // IDCODE readout, 37 TCK
        run_cmd(2'd1, 4, 32'h2, 32'h0, 32'h0, 0);
        check("tap_ir_2", tap_ir, exp_ir);
        run_cmd(2'd2, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);     // zero length
        run_cmd(2'd2, 40, $urandom, 32'h0, 32'h0, 0);         // clamped to 32
        run_cmd(2'd3, 3, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);

        for (int k = 0; k < 12; k++)
            run_cmd(($urandom_range(0, 3) == 0) ? 2'd3 : 2'd2, $urandom_range(0, 40),
                    $urandom, $urandom, $urandom, $urandom_range(0, 2));
        check("udr_model", tap_udr, exp_udr);

        run_cmd(2'd2, 20, $urandom, 32'h0, 32'h0, 10);        // backpressure hold

        run_cmd(2'd2, 32, 32'hA4, 32'h0, 32'h0, 0);
        run_cmd(2'd2, 8, $urandom, 32'hA5, 32'h0F, 0);        // mismatch expected
        run_cmd(2'd2, 32, 32'h55, 32'h0, 32'h0, 0);
        run_cmd(2'd2, 8, $urandom, 32'hA5, 32'h0F, 0);        // no mismatch

        run_cmd(2'd1, 4, 32'h1, 32'h0, 32'h0, 0);             // abort a 16-bit IDCODE shift
        rd = $urandom;
        @(negedge clk);
        cmd_type = 2'd2; cmd_len = 6'd16; cmd_data = rd; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_shift_busy", {busy, tap_st == SHDR}, 2'b11);
        do_reset();
        m = mon_n;
        repeat (20) @(negedge clk);
        check("no_rsp_after_abort", {rsp_valid, busy}, 2'b00);
        check("no_tck_after_abort", mon_n, m);
        run_cmd(2'd1, 4, 32'h2, 32'h0, 32'h0, 0);
        run_cmd(2'd2, 32, $urandom, 32'h0, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
